// File: rtl/tinyrv_pkg.sv
// -----------------------------------------------------------------------------
// tinyrv_pkg
// Shared constants and types for the TinyRISC-V front end.
//   RESET_PC       : first address fetched after reset
//   NOP_INST       : instruction presented to decode when nothing is held
//   fetch_entry_t  : {pc, inst} pair held in the fetch instruction buffer
//   align_word()   : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package tinyrv_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/sync_fifo2.sv
// -----------------------------------------------------------------------------
// sync_fifo2
// Two-entry synchronous FIFO with a combinational head output.
//   clk, rst : clock and asynchronous active-high reset (control state only)
//   push     : write wdata at the tail (accepted when not full, or when full
//              and popping in the same cycle)
//   pop      : drop the head entry (ignored when empty)
//   clear    : empty the FIFO; wins over push and pop
//   wdata    : data to write
//   full     : two entries held
//   empty    : no entries held
//   count    : number of entries held (0..2)
//   head     : oldest entry; undefined when empty
// -----------------------------------------------------------------------------
module sync_fifo2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] wdata,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        cnt;
    logic              do_push;
    logic              do_pop;

    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);
    assign count = cnt;
    assign head  = mem[rd_ptr];

    // When full, a simultaneous pop frees the head slot, which is exactly the
    // slot the write pointer addresses, so the push can proceed.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else if (clear) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries data only and needs no reset.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= wdata;
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && full && !pop && !clear));

    no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && empty && !clear));

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, issues in-order word fetches to imem,
// buffers returned instructions with their PCs and hands them to decode.
// Redirects from execute retarget the PC and discard stale in-flight data.
//   clk, rst          : clock, asynchronous active-high reset
//   imem_req_valid_o  : fetch request valid
//   imem_req_ready_i  : imem accepts the request
//   imem_addr_o       : fetch address (word aligned)
//   imem_rsp_valid_i  : in-order response valid
//   imem_rsp_data_i   : returned instruction word
//   jump_en_i         : redirect request
//   jump_addr_i       : redirect target (low two bits ignored)
//   id_valid_o        : instruction available to decode
//   id_ready_i        : decode accepts
//   id_inst_o         : instruction (NOP when nothing is held)
//   id_pc_o           : PC of id_inst_o (last delivered PC when empty)
// -----------------------------------------------------------------------------
module fetch_unit
    import tinyrv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid_o,
    input  logic        imem_req_ready_i,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rsp_valid_i,
    input  logic [31:0] imem_rsp_data_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        id_valid_o,
    input  logic        id_ready_i,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_pc_o
);

    logic [31:0]  pc_q;
    logic [31:0]  last_pc_q;
    logic [1:0]   drop_cnt;

    logic         req_fire;
    logic         id_pop;
    logic [2:0]   occupancy;
    logic [1:0]   inflight_after;

    logic         inf_full;
    logic         inf_empty;
    logic [1:0]   inf_cnt;
    logic [31:0]  inf_head_pc;

    logic         buf_push;
    logic         buf_full;
    logic         buf_empty;
    logic [1:0]   buf_cnt;
    fetch_entry_t buf_wdata;
    fetch_entry_t buf_head;

    // Request side: credit counts everything in flight plus everything held,
    // minus the entry decode is taking this cycle. Two credits total keeps the
    // instruction buffer from ever overflowing, even when every in-flight
    // response lands while decode stalls.
    assign id_pop    = id_valid_o && id_ready_i;
    assign occupancy = {1'b0, inf_cnt} + {1'b0, buf_cnt} - {2'b00, id_pop};

    assign imem_req_valid_o = !rst && !inf_full && (occupancy < 3'd2);
    assign imem_addr_o      = pc_q;
    assign req_fire         = imem_req_valid_o && imem_req_ready_i;

    // Entries still in flight at the end of this cycle; on a redirect all of
    // them belong to the old stream and must be discarded when they return.
    assign inflight_after = inf_cnt + {1'b0, req_fire} - {1'b0, imem_rsp_valid_i};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else if (jump_en_i) begin
            pc_q <= align_word(jump_addr_i);
        end else if (req_fire) begin
            pc_q <= pc_q + 32'd4;
        end
    end

    sync_fifo2 #(
        .DATA_W (32)
    ) u_inflight (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (imem_rsp_valid_i),
        .clear (1'b0),
        .wdata (pc_q),
        .full  (inf_full),
        .empty (inf_empty),
        .count (inf_cnt),
        .head  (inf_head_pc)
    );

    // Response side: a response consumed in a redirect cycle is stale too,
    // so it never enters the buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= 2'd0;
        end else if (jump_en_i) begin
            drop_cnt <= inflight_after;
        end else if (imem_rsp_valid_i && (drop_cnt != 2'd0)) begin
            drop_cnt <= drop_cnt - 2'd1;
        end
    end

    assign buf_push       = imem_rsp_valid_i && (drop_cnt == 2'd0) && !jump_en_i;
    assign buf_wdata.pc   = inf_head_pc;
    assign buf_wdata.inst = imem_rsp_data_i;

    sync_fifo2 #(
        .DATA_W ($bits(fetch_entry_t))
    ) u_ibuf (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .pop   (id_pop),
        .clear (jump_en_i),
        .wdata (buf_wdata),
        .full  (buf_full),
        .empty (buf_empty),
        .count (buf_cnt),
        .head  (buf_head)
    );

    // Decode side: the handshake in a redirect cycle still completes; only
    // the entries behind it are flushed by the buffer clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_pc_q <= RESET_PC;
        end else if (id_pop) begin
            last_pc_q <= buf_head.pc;
        end
    end

    assign id_valid_o = !buf_empty;
    assign id_inst_o  = id_valid_o ? buf_head.inst : NOP_INST;
    assign id_pc_o    = id_valid_o ? buf_head.pc   : last_pc_q;

    ibuf_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(buf_push && buf_full && !id_pop));

    rsp_has_request: assert property (@(posedge clk) disable iff (rst)
        !(imem_rsp_valid_i && inf_empty));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i;
    logic [31:0] imem_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        id_valid_o;
    logic        id_ready_i;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;

    typedef struct {
        logic [31:0] a;
        int          t;
    } ev_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          t;
    } dec_t;

    localparam logic [31:0] SALT = 32'hA5A5_0000;

    ev_t  imem_q[$];
    ev_t  req_log[$];
    dec_t dec_log[$];
    int   cyc;
    int   lat;
    int   n_chk;
    int   n_err;

    fetch_unit dut (
        .clk              (clk),
        .rst              (rst),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_addr_o      (imem_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .jump_en_i        (jump_en_i),
        .jump_addr_i      (jump_addr_i),
        .id_valid_o       (id_valid_o),
        .id_ready_i       (id_ready_i),
        .id_inst_o        (id_inst_o),
        .id_pc_o          (id_pc_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive the imem response due this cycle, record what the
    // upcoming edge will accept, then advance past the edge.
    task automatic step();
        ev_t  e;
        dec_t d;
        if (rst) imem_q.delete();
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        if (imem_q.size() > 0 && imem_q[0].t <= cyc) begin
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = imem_q[0].a ^ SALT;
            void'(imem_q.pop_front());
        end
        #1;
        if (!rst && imem_req_valid_o && imem_req_ready_i) begin
            e.a = imem_addr_o;
            e.t = cyc + lat;
            imem_q.push_back(e);
            e.t = cyc;
            req_log.push_back(e);
        end
        if (!rst && id_valid_o && id_ready_i) begin
            d.pc   = id_pc_o;
            d.inst = id_inst_o;
            d.t    = cyc;
            dec_log.push_back(d);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        jump_en_i        = 1'b0;
        id_ready_i       = 1'b1;
        imem_req_ready_i = 1'b1;
        run(2);
        rst = 1'b0;
        cyc = 0;
        req_log.delete();
        dec_log.delete();
    endtask

    initial begin
        n_chk            = 0;
        n_err            = 0;
        cyc              = 0;
        lat              = 1;
        rst              = 1'b1;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
        jump_en_i        = 1'b0;
        jump_addr_i      = 32'h0;
        id_ready_i       = 1'b1;

        // Reset hold
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
            chk("rst_id_valid", {31'b0, id_valid_o}, 32'd0);
        end
        chk("rst_addr", imem_addr_o, 32'h0);
        chk("rst_inst", id_inst_o, 32'h0000_0013);
        chk("rst_pc", id_pc_o, 32'h0);
        rst = 1'b0;
        cyc = 0;
        req_log.delete();
        dec_log.delete();

        // Boot then back-pressure
        run(4);
        id_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("bp_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
            chk("bp_id_pc", id_pc_o, 32'h8);
        end
        id_ready_i = 1'b1;
        run(10);
        chk("boot_req_cnt", req_log.size(), 32'd14);
        chk("boot_dec_cnt", dec_log.size(), 32'd12);
        for (int i = 0; i < 14 && i < req_log.size(); i++)
            chk("boot_req_addr", req_log[i].a, 32'(4 * i));
        for (int i = 0; i < 3 && i < req_log.size(); i++)
            chk("boot_req_cyc", req_log[i].t, 32'(i));
        for (int i = 0; i < 12 && i < dec_log.size(); i++) begin
            chk("boot_dec_pc", dec_log[i].pc, 32'(4 * i));
            chk("boot_dec_inst", dec_log[i].inst, 32'(4 * i) ^ SALT);
        end
        if (dec_log.size() >= 3) begin
            chk("boot_dec_cyc0", dec_log[0].t, 32'd2);
            chk("boot_dec_cyc1", dec_log[1].t, 32'd3);
            chk("bp_resume_cyc", dec_log[2].t, 32'd10);
        end

        // imem stall at 0x10
        do_reset();
        run(4);
        imem_req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_addr", imem_addr_o, 32'h10);
            chk("stall_req_valid", {31'b0, imem_req_valid_o}, 32'd1);
        end
        imem_req_ready_i = 1'b1;
        run(4);
        chk("stall_req_cnt", req_log.size(), 32'd8);
        for (int i = 0; i < 8 && i < req_log.size(); i++)
            chk("stall_req_addr", req_log[i].a, 32'(4 * i));
        if (req_log.size() > 4) chk("stall_accept_cyc", req_log[4].t, 32'd8);

        // Redirect with two in flight, 3-cycle imem
        lat = 3;
        do_reset();
        run(2);
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0100;
        step();
        jump_en_i = 1'b0;
        chk("jmp_addr", imem_addr_o, 32'h100);
        run(7);
        chk("jmp_dec_cnt", dec_log.size(), 32'd2);
        if (dec_log.size() >= 2) begin
            chk("jmp_dec0_pc", dec_log[0].pc, 32'h100);
            chk("jmp_dec0_inst", dec_log[0].inst, 32'hA5A5_0100);
            chk("jmp_dec0_cyc", dec_log[0].t, 32'd8);
            chk("jmp_dec1_pc", dec_log[1].pc, 32'h104);
        end
        if (req_log.size() >= 4) begin
            chk("jmp_req_addr", req_log[2].a, 32'h100);
            chk("jmp_req_cyc", req_log[2].t, 32'd4);
            chk("jmp_req_next", req_log[3].a, 32'h104);
        end

        // Misaligned redirect colliding with response and handshake, then 0x200
        lat = 1;
        do_reset();
        run(3);
        jump_en_i   = 1'b1;
        jump_addr_i = 32'h0000_0102;
        step();
        chk("mis_addr", imem_addr_o, 32'h100);
        jump_addr_i = 32'h0000_0200;
        step();
        jump_en_i = 1'b0;
        chk("b2b_addr", imem_addr_o, 32'h200);
        run(4);
        chk("b2b_dec_cnt", dec_log.size(), 32'd4);
        if (dec_log.size() >= 4) begin
            chk("b2b_hs_pc", dec_log[1].pc, 32'h4);
            chk("b2b_hs_cyc", dec_log[1].t, 32'd3);
            chk("b2b_dec2_pc", dec_log[2].pc, 32'h200);
            chk("b2b_dec2_inst", dec_log[2].inst, 32'hA5A5_0200);
            chk("b2b_dec3_pc", dec_log[3].pc, 32'h204);
        end
        if (req_log.size() >= 6) begin
            chk("mis_req_addr", req_log[4].a, 32'h100);
            chk("mis_req_cyc", req_log[4].t, 32'd4);
            chk("b2b_req_addr", req_log[5].a, 32'h200);
        end

        // PC wrap, then reset mid-stream
        do_reset();
        jump_en_i   = 1'b1;
        jump_addr_i = 32'hFFFF_FFF8;
        step();
        jump_en_i = 1'b0;
        run(5);
        if (req_log.size() >= 4) begin
            chk("wrap_req1", req_log[1].a, 32'hFFFF_FFF8);
            chk("wrap_req2", req_log[2].a, 32'hFFFF_FFFC);
            chk("wrap_req3", req_log[3].a, 32'h0);
        end else begin
            chk("wrap_req_cnt", req_log.size(), 32'd4);
        end
        chk("wrap_dec_cnt", dec_log.size(), 32'd3);
        if (dec_log.size() >= 3) begin
            chk("wrap_dec0_pc", dec_log[0].pc, 32'hFFFF_FFF8);
            chk("wrap_dec0_inst", dec_log[0].inst, 32'h5A5A_FFF8);
            chk("wrap_dec1_pc", dec_log[1].pc, 32'hFFFF_FFFC);
            chk("wrap_dec2_pc", dec_log[2].pc, 32'h0);
            chk("wrap_dec2_inst", dec_log[2].inst, 32'hA5A5_0000);
        end
        chk("pre_rst_valid", {31'b0, id_valid_o}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_id_valid", {31'b0, id_valid_o}, 32'd0);
        chk("mid_rst_req_valid", {31'b0, imem_req_valid_o}, 32'd0);
        chk("mid_rst_addr", imem_addr_o, 32'h0);
        step();
        rst = 1'b0;
        cyc = 0;
        req_log.delete();
        dec_log.delete();
        run(3);
        if (req_log.size() >= 2) begin
            chk("restart_req0", req_log[0].a, 32'h0);
            chk("restart_req0_cyc", req_log[0].t, 32'd0);
            chk("restart_req1", req_log[1].a, 32'h4);
        end else begin
            chk("restart_req_cnt", req_log.size(), 32'd2);
        end
        if (dec_log.size() >= 1) chk("restart_dec_pc", dec_log[0].pc, 32'h0);
        else                     chk("restart_dec_cnt", dec_log.size(), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of TinyRISC-V. It sits between the instruction memory port and the decode stage. It owns the PC and issues in-order word fetches to imem over a valid/ready request channel with variable response latency. It buffers returned instructions with their PCs and presents them to decode over a valid/ready handshake. It also handles redirects (jump/branch/flush) from execute, discarding any in-flight stale responses.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset.
- `NOP_INST`, 32'h0000_0013, value driven on `id_inst_o` when nothing valid is held.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `imem_req_valid_o` out 1: fetch request valid.
- `imem_req_ready_i` in 1: imem accepts request.
- `imem_addr_o` out 32: fetch address, word aligned.
- `imem_rsp_valid_i` in 1: response valid. Responses are in order, at least 1 cycle after acceptance.
- `imem_rsp_data_i` in 32: instruction word.
- `jump_en_i` in 1: redirect request from execute.
- `jump_addr_i` in 32: redirect target. Bits [1:0] are ignored (forced 0).
- `id_valid_o` out 1: instruction available to decode.
- `id_ready_i` in 1: decode accepts.
- `id_inst_o` out 32: instruction.
- `id_pc_o` out 32: PC of `id_inst_o`.

## Operation
- State:
  - `pc_q`: next fetch address.
  - In-flight PC FIFO, 2 entries.
  - Instruction buffer, 2 entries of {pc, inst}.
  - `drop_cnt` (0..2).
- Issue rule: `imem_req_valid_o = !rst && (inflight_cnt + buf_cnt − pop) < 2`, where pop is `id_valid_o && id_ready_i`.
- `imem_addr_o = pc_q`. On acceptance (`imem_req_valid_o && imem_req_ready_i`): push `pc_q` into the in-flight FIFO, then `pc_q += 4`. The adder wraps modulo 2^32 (0xFFFF_FFFC → 0x0).
- While a request waits for ready, `imem_addr_o` is stable.
- Response arrival:
  - If `drop_cnt > 0`: decrement `drop_cnt`, pop the in-flight FIFO, discard the data.
  - Otherwise: pop the in-flight FIFO and push {pc, data} into the instruction buffer.
  - The credit rule guarantees the buffer never overflows. Overflow is an assertion failure.
- Decode side:
  - `id_valid_o = buf_cnt != 0`.
  - `id_inst_o`/`id_pc_o` come from the buffer head. When empty they are `NOP_INST`/last PC.
  - Pop on handshake. Push and pop in the same cycle are legal, including at `buf_cnt` = 1 or 2.
- Redirect (`jump_en_i`):
  - Next cycle `pc_q = {jump_addr_i[31:2], 2'b00}`.
  - The instruction buffer is cleared. A pop in the same cycle still counts as a completed transfer.
  - `drop_cnt` = in-flight entries remaining after this cycle. This counts a request accepted this cycle, and excludes a response consumed this cycle, which is itself discarded.
  - Back-to-back redirects: the last one wins. `drop_cnt` is recomputed each time.
- Reset mid-operation clears everything immediately. Responses to pre-reset requests are the imem's responsibility: the imem port is reset by the same `rst`.

## Timing
- Reset values:
  - `imem_req_valid_o` = 0.
  - `imem_addr_o` = `RESET_PC`.
  - `id_valid_o` = 0.
  - `id_inst_o` = `NOP_INST`.
  - `id_pc_o` = `RESET_PC`.
  - `drop_cnt` = 0; all FIFOs empty.
- First request is in the first cycle after `rst` deasserts.
- Response to decode: `id_valid_o` rises the cycle after `imem_rsp_valid_i`.
- Throughput: with a 1-cycle imem and `id_ready_i` = 1, one instruction per cycle is sustained.
- Redirect penalty: the target request issues 1 cycle after `jump_en_i`. The target instruction reaches decode no earlier than 3 cycles after `jump_en_i`.
- The only combinational input→output path is `id_ready_i` → `imem_req_valid_o` (through pop).

## Structure
- Shared package `tinyrv_pkg`: `RESET_PC`, `NOP_INST`, and the `fetch_entry_t` struct {pc[31:0], inst[31:0]}.
- Sub-module `sync_fifo2`:
  - Parameterised width, 2 entries.
  - Ports: push, pop, clear, full, empty, count, head.
  - Instantiated twice: in-flight PC FIFO (width 32), instruction buffer (width 64).

## Test plan
- Reset/boot: hold `rst` 3 cycles, checking outputs at reset values. Release with 1-cycle imem returning `addr ^ 32'hA5A5_0000` → requests at 0x0, 0x4, 0x8 on consecutive cycles; decode sees matching pc/inst pairs, one per cycle, from cycle 2.
- Back-pressure: `id_ready_i` = 0 for 6 cycles → at most 2 buffered plus 0 extra in flight, `imem_req_valid_o` low. On release, the PC sequence continues gapless and in order with no duplicates.
- imem stall: `imem_req_ready_i` = 0 for 4 cycles at addr 0x10 → `imem_addr_o` holds 0x10, no PC advance.
- Redirect with 2 in flight (3-cycle imem): `jump_en_i` with target 0x100 → both stale responses dropped. The next decode pair is pc=0x100, then 0x104.
- Misaligned and simultaneous redirect: target 0x0000_0102 asserted in the same cycle as `imem_rsp_valid_i` and an id handshake → the handshake completes, the response is discarded, and the next fetch is 0x100. Follow with a second jump to 0x200 on the next cycle → only the 0x200 stream appears.
- Wrap and mid-run reset: set PC to 0xFFFF_FFF8 via jump → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. Assert `rst` mid-stream → `id_valid_o` drops in the same cycle, and after release fetching restarts at `RESET_PC`.
